// File: rtl/bit_adj_16b_to_32b_pkg.sv
// Shared constants and helpers for the Q3.12 -> Q7.24 bit adjuster.
//
// Contents:
//   IN_W, OUT_W        input and output sample widths
//   FRAC_SHIFT         zero bits appended below the input LSB
//   SIGN_EXT_W         sign bits replicated above the input MSB
//   FRAME_LEN_DEFAULT  default samples per FFT frame
//   skid_state_t       occupancy states of the 2-entry skid buffer
//   widen()            exact sign-extend and shift of one sample
package bit_adj_16b_to_32b_pkg;

    localparam int IN_W              = 16;
    localparam int OUT_W             = 32;
    localparam int FRAC_SHIFT        = 12;
    localparam int SIGN_EXT_W        = 4;
    localparam int FRAME_LEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Q3.12 -> Q7.24: four sign bits on top, twelve zero bits below.
    // Purely a bit rearrangement, so no rounding or saturation exists.
    function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] din);
        return {{SIGN_EXT_W{din[IN_W-1]}}, din, {FRAC_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/bit_adj_16b_to_32b_skid_buf.sv
// skid_buf_32b: 2-entry skid buffer carrying 32-bit words.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream offers in_data
//   in_ready   registered; 1 whenever the buffer is not FULL
//   in_data    32-bit word to store
//   out_valid  registered; 1 whenever the buffer is ONE or FULL
//   out_ready  downstream takes out_data this cycle
//   out_data   registered head word
//   dbg_state  current occupancy state (skid_state_t encoding)
//
// Handshake: a word moves across an interface on a rising edge where
// valid & ready are both 1. in_ready depends only on registered state, so
// there is no combinational path from out_ready to in_ready.
module skid_buf_32b
    import bit_adj_16b_to_32b_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       dbg_state
);

    skid_state_t      state;
    logic [OUT_W-1:0] tail;
    logic             push;
    logic             pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign dbg_state = state;

    // out_data is the head entry; tail only holds a word while FULL.
    // in_ready and out_valid are updated alongside state so they always
    // equal (state != FULL) and (state != EMPTY) outside of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    // Also the first cycle out of reset: open the input.
                    in_ready <= 1'b1;
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_data <= in_data;
                    end else if (push) begin
                        tail     <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is 0 here, so only a pop can occur.
                    if (pop) begin
                        out_data <= tail;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/bit_adj_16b_to_32b.sv
// bit_adj_16b_to_32b: widens signed Q3.12 samples to Q7.24-aligned 32-bit
// words and passes them through a 2-entry skid buffer, optionally marking
// the last sample of each FFT frame.
//
// Configuration macro: BIT_ADJ_FRAME_CNT_EN
//   defined   -> frame counter present, Out_last marks sample FRAME_LEN-1
//   undefined -> no counter, Out_last tied to 0
//
// Parameters:
//   FRAME_LEN  samples per frame (power of two, 2..1024)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   In_valid   Data_in holds a sample
//   In_ready   registered; block accepts a sample this cycle
//   Data_in    signed Q3.12 sample
//   Out_valid  Data_out holds a sample
//   Out_ready  downstream accepts Data_out this cycle
//   Data_out   signed Q7.24-aligned sample
//   Out_last   Data_out is the final sample of a frame
module bit_adj_16b_to_32b
    import bit_adj_16b_to_32b_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [IN_W-1:0]  Data_in,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [OUT_W-1:0] Data_out,
    output logic             Out_last
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [OUT_W-1:0] wide_data;
    logic [1:0]       unused_buf_state;

    // Widen before storage so the buffer only ever holds final words.
    assign wide_data = widen(Data_in);

    skid_buf_32b u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (In_valid),
        .in_ready  (In_ready),
        .in_data   (wide_data),
        .out_valid (Out_valid),
        .out_ready (Out_ready),
        .out_data  (Data_out),
        .dbg_state (unused_buf_state)
    );

`ifdef BIT_ADJ_FRAME_CNT_EN
    logic [CNT_W-1:0] frame_cnt;

    // Counts output handshakes; the value is the frame index of the word
    // currently on Data_out, so it only moves when that word leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (Out_valid && Out_ready) begin
            if (frame_cnt == CNT_W'(FRAME_LEN - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    assign Out_last = Out_valid && (frame_cnt == CNT_W'(FRAME_LEN - 1));
`else
    logic [CNT_W-1:0] unused_frame_cnt;

    assign unused_frame_cnt = '0;
    assign Out_last         = 1'b0;
`endif

endmodule

// File: tb/tb_bit_adj_16b_to_32b.sv
`timescale 1ns/1ps
module tb_bit_adj_16b_to_32b;

    localparam int FRAME_LEN = 64;
`ifdef BIT_ADJ_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        In_valid  = 1'b0;
    logic        Out_ready = 1'b0;
    logic [15:0] Data_in   = 16'h0000;
    logic        In_ready;
    logic        Out_valid;
    logic        Out_last;
    logic [31:0] Data_out;

    always #5 clk = ~clk;

    bit_adj_16b_to_32b #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Data_in   (Data_in),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Data_out  (Data_out),
        .Out_last  (Out_last)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int errors   = 0;
    int acc_cnt  = 0;
    int out_cnt  = 0;
    int last_cnt = 0;
    int hs_idx   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;

    typedef struct {
        logic [15:0] din;
        logic [31:0] dout;
    } vec_t;

    function automatic logic [31:0] model_widen(input logic [15:0] d);
        return {{4{d[15]}}, d, 12'h000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled at negedge: the values seen here are what the next rising
    // edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hs_idx     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(Out_valid), 32'd1);
                check("hold_data", Data_out, prev_data);
            end
            if (Out_valid && Out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_data", Data_out, sb_exp);
                end
                check("sb_last", 32'(Out_last),
                      32'(CNT_EN && ((hs_idx % FRAME_LEN) == FRAME_LEN - 1)));
                if (Out_last) last_cnt++;
                hs_idx++;
            end
            if (In_valid && In_ready) begin
                exp_q.push_back(model_widen(Data_in));
                acc_cnt++;
            end
            prev_stall = Out_valid && !Out_ready;
            prev_data  = Data_out;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs[8];
        int a0, o0, l0, ir_low, sent, cyc;
        logic accepted;

        vecs[0] = '{16'h1000, 32'h0100_0000};
        vecs[1] = '{16'h7FFF, 32'h07FF_F000};
        vecs[2] = '{16'h8000, 32'hF800_0000};
        vecs[3] = '{16'hFFFF, 32'hFFFF_F000};
        vecs[4] = '{16'h0000, 32'h0000_0000};
        vecs[5] = '{16'h0001, 32'h0000_1000};
        vecs[6] = '{16'h1234, 32'h0123_4000};
        vecs[7] = '{16'hABCD, 32'hFABC_D000};

        // Reset state
        rst = 1'b1;
        In_valid = 1'b1;
        Data_in  = 16'h5555;
        repeat (3) tick();
        check("rst_in_ready", 32'(In_ready), 32'd0);
        check("rst_out_valid", 32'(Out_valid), 32'd0);
        check("rst_data_out", Data_out, 32'h0);
        check("rst_out_last", 32'(Out_last), 32'd0);
        rst = 1'b0;
        In_valid = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(In_ready), 32'd1);
        check("out_valid_after_rst", 32'(Out_valid), 32'd0);

        // Widening table, one sample at a time with 1-cycle latency
        Out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            In_valid = 1'b1;
            Data_in  = vecs[i].din;
            tick();
            In_valid = 1'b0;
            check("widen_valid", 32'(Out_valid), 32'd1);
            check("widen_data", Data_out, vecs[i].dout);
            tick();
            check("widen_drained", 32'(Out_valid), 32'd0);
        end

        // Backpressure: three offered, two taken
        a0 = acc_cnt;
        Out_ready = 1'b0;
        In_valid  = 1'b1;
        Data_in   = 16'h0011;
        tick();
        check("bp_ready_after_1st", 32'(In_ready), 32'd1);
        Data_in = 16'h0022;
        tick();
        check("bp_ready_after_2nd", 32'(In_ready), 32'd0);
        check("bp_head_1st", Data_out, 32'h0001_1000);
        Data_in = 16'h0033;
        tick();
        check("bp_accepted_2", 32'(acc_cnt - a0), 32'd2);
        check("bp_hold_head", Data_out, 32'h0001_1000);
        tick();
        check("bp_still_full", 32'(In_ready), 32'd0);
        Out_ready = 1'b1;
        tick();
        check("bp_out_2nd", Data_out, 32'h0002_2000);
        check("bp_ready_reopen", 32'(In_ready), 32'd1);
        tick();
        In_valid = 1'b0;
        check("bp_out_3rd", Data_out, 32'h0003_3000);
        tick();
        check("bp_empty", 32'(Out_valid), 32'd0);
        check("bp_accepted_3", 32'(acc_cnt - a0), 32'd3);

        // Streaming: 200 samples back to back
        a0 = acc_cnt;
        o0 = out_cnt;
        ir_low = 0;
        Out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            In_valid = 1'b1;
            Data_in  = 16'(i * 311 + 32769);
            if (!In_ready) ir_low++;
            tick();
        end
        check("stream_ready_drops", 32'(ir_low), 32'd0);
        check("stream_out_in_window", 32'(out_cnt - o0), 32'd199);
        In_valid = 1'b0;
        tick();
        tick();
        check("stream_accepted", 32'(acc_cnt - a0), 32'd200);
        check("stream_outputs", 32'(out_cnt - o0), 32'd200);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frame marking: 130 samples with random backpressure
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        o0 = out_cnt;
        l0 = last_cnt;
        sent = 0;
        cyc  = 0;
        while ((sent < 130 || Out_valid) && cyc < 3000) begin
            In_valid  = (sent < 130);
            Data_in   = 16'(sent * 593 + 7);
            Out_ready = 1'($urandom_range(0, 1));
            accepted  = In_valid && In_ready;
            tick();
            cyc++;
            if (accepted) sent++;
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        check("frame_done_in_budget", 32'(cyc < 3000), 32'd1);
        check("frame_outputs", 32'(out_cnt - o0), 32'd130);
        check("frame_last_count", 32'(last_cnt - l0), CNT_EN ? 32'd2 : 32'd0);

        // Reset while FULL at frame sample 10
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        Out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            In_valid = 1'b1;
            Data_in  = 16'(i + 100);
            tick();
        end
        In_valid = 1'b0;
        tick();
        check("rf_ten_out", 32'(hs_idx), 32'd10);
        Out_ready = 1'b0;
        In_valid  = 1'b1;
        Data_in   = 16'h0AAA;
        tick();
        Data_in = 16'h0BBB;
        tick();
        check("rf_full_ready", 32'(In_ready), 32'd0);
        check("rf_full_head", Data_out, 32'h00AA_A000);
        rst = 1'b1;
        Data_in = 16'h0CCC;
        tick();
        rst = 1'b0;
        In_valid = 1'b0;
        check("rf_valid_cleared", 32'(Out_valid), 32'd0);
        check("rf_ready_in_rst", 32'(In_ready), 32'd0);
        check("rf_data_cleared", Data_out, 32'h0);
        check("rf_last_cleared", 32'(Out_last), 32'd0);
        tick();
        check("rf_ready_release", 32'(In_ready), 32'd1);
        check("rf_still_empty", 32'(Out_valid), 32'd0);
        o0 = out_cnt;
        l0 = last_cnt;
        Out_ready = 1'b1;
        In_valid  = 1'b1;
        Data_in   = 16'h4321;
        tick();
        check("rf_first_valid", 32'(Out_valid), 32'd1);
        check("rf_first_data", Data_out, 32'h0432_1000);
        check("rf_first_not_last", 32'(Out_last), 32'd0);
        for (int i = 1; i < 64; i++) begin
            Data_in = 16'(i * 1021);
            tick();
        end
        In_valid = 1'b0;
        tick();
        tick();
        check("rf_outputs", 32'(out_cnt - o0), 32'd64);
        check("rf_last_count", 32'(last_cnt - l0), CNT_EN ? 32'd1 : 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
